// File: rtl/axil_ipif_bridge.sv
// AXI4-Lite slave bridging to an IPIF bus2ip/ip2bus register interface.
// Serves one transaction at a time, round-robin between reads and writes, with ack timeout.
module axil_ipif_bridge #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_NUM_REG    = 4,
  parameter int C_TIMEOUT    = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [C_ADDR_WIDTH-1:0]           AWADDR,
  input  logic                              WVALID,
  output logic                              WREADY,
  input  logic [C_DATA_WIDTH-1:0]           WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]         WSTRB,
  output logic                              BVALID,
  input  logic                              BREADY,
  output logic [1:0]                        BRESP,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  input  logic [C_ADDR_WIDTH-1:0]           ARADDR,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [C_DATA_WIDTH-1:0]           RDATA,
  output logic [1:0]                        RRESP,
  output logic                              bus2ip_clk,
  output logic [C_ADDR_WIDTH-1:0]           bus2ip_addr,
  output logic [C_DATA_WIDTH-1:0]           bus2ip_data,
  output logic [C_DATA_WIDTH/8-1:0]         bus2ip_be,
  output logic [C_NUM_REG-1:0]              bus2ip_wrce,
  output logic [C_NUM_REG-1:0]              bus2ip_rdce,
  input  logic [C_NUM_REG*C_DATA_WIDTH-1:0] ip2bus_data,
  input  logic                              ip2bus_rdack,
  input  logic                              ip2bus_wrack
);
  localparam int LSB = $clog2(C_DATA_WIDTH/8);
  localparam int IW  = (C_NUM_REG > 1) ? $clog2(C_NUM_REG) : 1;
  localparam logic [C_NUM_REG-1:0] ONE = C_NUM_REG'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_WAIT = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;

  logic [2:0]              state;
  logic                    rr_last;  // 1: read served last, 0: write served last
  logic [7:0]              tcnt;
  logic [IW-1:0]           idx_q;
  logic                    in_idle, wr_elig, grant_rd, grant_wr, acc_dec, expired;
  logic [C_ADDR_WIDTH-1:0] acc_addr;
  logic [IW-1:0]           acc_idx;
  logic [C_NUM_REG-1:0]    acc_oh;

  assign bus2ip_clk = ACLK;

  // Ready is a combinational grant so a transaction can be accepted on the cycle it arrives.
  assign in_idle  = (state == S_IDLE) && !ARESET;
  assign wr_elig  = AWVALID && WVALID;
  assign grant_rd = in_idle && ARVALID && (!wr_elig || !rr_last);
  assign grant_wr = in_idle && wr_elig && !grant_rd;
  assign AWREADY  = grant_wr;
  assign WREADY   = grant_wr;
  assign ARREADY  = grant_rd;

  assign acc_addr = grant_wr ? AWADDR : ARADDR;
  assign acc_idx  = (C_NUM_REG > 1) ? acc_addr[LSB +: IW] : '0;
  assign acc_dec  = ({1'b0, acc_idx} >= (IW+1)'(C_NUM_REG));
  assign acc_oh   = ONE << acc_idx;
  assign expired  = (tcnt == 8'(C_TIMEOUT - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= S_IDLE;
      rr_last     <= 1'b0;
      tcnt        <= '0;
      idx_q       <= '0;
      BVALID      <= 1'b0;
      BRESP       <= 2'b00;
      RVALID      <= 1'b0;
      RRESP       <= 2'b00;
      RDATA       <= '0;
      bus2ip_addr <= '0;
      bus2ip_data <= '0;
      bus2ip_be   <= '0;
      bus2ip_wrce <= '0;
      bus2ip_rdce <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (grant_wr) begin
            rr_last     <= 1'b0;
            idx_q       <= acc_idx;
            bus2ip_addr <= AWADDR;
            bus2ip_data <= WDATA;
            bus2ip_be   <= WSTRB;
            if (acc_dec) begin
              state  <= S_WR_RESP;
              BVALID <= 1'b1;
              BRESP  <= 2'b11;
            end else begin
              state       <= S_WR_WAIT;
              bus2ip_wrce <= acc_oh;
            end
          end else if (grant_rd) begin
            rr_last     <= 1'b1;
            idx_q       <= acc_idx;
            bus2ip_addr <= ARADDR;
            bus2ip_be   <= '1;
            if (acc_dec) begin
              state  <= S_RD_RESP;
              RVALID <= 1'b1;
              RRESP  <= 2'b11;
            end else begin
              state       <= S_RD_WAIT;
              bus2ip_rdce <= acc_oh;
            end
          end
        end
        S_WR_WAIT: begin
          // An ack on the expiry cycle still counts as a good completion.
          if (ip2bus_wrack || expired) begin
            bus2ip_wrce <= '0;
            BVALID      <= 1'b1;
            BRESP       <= ip2bus_wrack ? 2'b00 : 2'b10;
            state       <= S_WR_RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RD_WAIT: begin
          if (ip2bus_rdack || expired) begin
            bus2ip_rdce <= '0;
            RVALID      <= 1'b1;
            RRESP       <= ip2bus_rdack ? 2'b00 : 2'b10;
            RDATA       <= ip2bus_rdack ? ip2bus_data[idx_q*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
            state       <= S_RD_RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            BRESP  <= 2'b00;
            state  <= S_IDLE;
          end
        end
        S_RD_RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            RRESP  <= 2'b00;
            RDATA  <= '0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/axil_ipif_bridge.md
Name: axil_ipif_bridge

Overview:
Parametrised AXI4-Lite slave that bridges to the IPIF-style bus2ip/ip2bus register interface used by the SPI peripheral.
- Generalised in register count and data width.
- Adds a full write-response (B) channel, byte strobes, address-decode errors and an ack timeout.
- Processes one transaction at a time and arbitrates round-robin between reads and writes.
- Sits between the AXI-Lite interconnect and the peripheral register file.

Parameters:
C_DATA_WIDTH, 32, AXI/IPIF data width in bits; must be 32 or 64.
C_ADDR_WIDTH, 32, AXI address width.
C_NUM_REG, 4, number of registers (CE lines); 1 to 16.
C_TIMEOUT, 16, cycles to wait for ip2bus ack before SLVERR; 2 to 255.

Ports:
ACLK  in  1  clock; all logic on its rising edge.
ARESET  in  1  asynchronous, active-high reset.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address accepted.
AWADDR  in  C_ADDR_WIDTH  write byte address.
WVALID  in  1  write data valid.
WREADY  out  1  write data accepted.
WDATA  in  C_DATA_WIDTH  write data.
WSTRB  in  C_DATA_WIDTH/8  write byte strobes.
BVALID  out  1  write response valid.
BREADY  in  1  write response accepted.
BRESP  out  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address accepted.
ARADDR  in  C_ADDR_WIDTH  read byte address.
RVALID  out  1  read data valid.
RREADY  in  1  read data accepted.
RDATA  out  C_DATA_WIDTH  read data.
RRESP  out  2  read response; same encoding as BRESP.
bus2ip_clk  out  1  equal to ACLK.
bus2ip_addr  out  C_ADDR_WIDTH  latched transaction address.
bus2ip_data  out  C_DATA_WIDTH  latched WDATA.
bus2ip_be  out  C_DATA_WIDTH/8  latched WSTRB on writes; all ones on reads.
bus2ip_wrce  out  C_NUM_REG  one-hot write chip enable.
bus2ip_rdce  out  C_NUM_REG  one-hot read chip enable.
ip2bus_data  in  C_NUM_REG*C_DATA_WIDTH  register readback; register i occupies slice [i*C_DATA_WIDTH +: C_DATA_WIDTH].
ip2bus_rdack  in  1  read acknowledge.
ip2bus_wrack  in  1  write acknowledge.

Behaviour:
- Reset: all outputs 0 except bus2ip_clk; state IDLE; rr_last=0 (read preferred first).
- Mid-transaction reset: transaction dropped, CE lines cleared asynchronously, no response issued.
- Register index: addr bits [log2(C_DATA_WIDTH/8) +: ceil(log2(C_NUM_REG))], i.e. [2+:2] for the defaults.
- Address bits above the index field are ignored.
- Index >= C_NUM_REG gives DECERR.
- FSM states: IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE, write eligible: a write is eligible only when AWVALID and WVALID are both high.
- IDLE, arbitration: if a read and a write are both eligible, the type not serviced last wins; rr_last records the type serviced.
- IDLE, write accept: AWREADY and WREADY pulse high together for exactly one cycle; AWADDR, WDATA and WSTRB are latched.
- IDLE, read accept: ARREADY pulses high for one cycle; ARADDR is latched.
- IDLE, next state: decoded index is WR_WAIT or RD_WAIT; DECERR goes straight to WR_RESP or RD_RESP with no CE asserted.
- WR_WAIT: bus2ip_wrce[idx] held high starting the cycle after accept, until ip2bus_wrack is sampled high.
- WR_WAIT exit: CE drops the next cycle, state moves to WR_RESP, BRESP=00.
- RD_WAIT: bus2ip_rdce[idx] held high until ip2bus_rdack.
- RD_WAIT exit: RDATA captures slice idx of ip2bus_data on the rdack cycle; RRESP=00; state moves to RD_RESP.
- Timeout: counter cleared on entry to a WAIT state and increments each WAIT cycle.
- Timeout expiry: after C_TIMEOUT cycles with no ack, CE drops and the response is SLVERR (10); on reads RDATA=0.
- Ack on the same cycle as timeout expiry: ack wins, response OKAY.
- WR_RESP / RD_RESP: BVALID/RVALID and the response fields held stable until BREADY/RREADY is sampled high; then the valid drops and the state returns to IDLE.
- Best latency: accept cycle, CE one cycle, valid on the following cycle; at most one ready pulse per 3 cycles.
- RDATA/RRESP/BRESP: 0 whenever the corresponding valid is low.
- ip2bus acks outside the matching WAIT state are ignored.
- AW without W (or W without AW): not accepted; the other channel is still serviceable.

Test Plan:
1. Write AWADDR=0x4, WDATA=0xA5A5_0001, WSTRB=0xF, wrack 2 cycles after CE -> wrce=0010 for 2 cycles; bus2ip_data=0xA5A50001; BVALID with BRESP=00; AWREADY/WREADY one-cycle pulse.
2. Read ARADDR=0xC with ip2bus_data[127:96]=0xDEAD_BEEF, rdack on first CE cycle -> rdce=1000 for 1 cycle; RDATA=0xDEADBEEF, RRESP=00; RVALID held while RREADY=0 for 3 cycles.
3. C_NUM_REG=3, read ARADDR=0xC -> no rdce; RRESP=11; RDATA=0.
4. Write to 0x8 with no wrack -> wrce=0100 for exactly 16 cycles, then BRESP=10; a later wrack is ignored.
5. AWVALID+WVALID and ARVALID asserted together twice in a row after reset -> read served first, then write, then read (round-robin).
6. Assert ARESET during RD_WAIT -> rdce clears immediately, no RVALID; next read after reset completes normally.
